// File: rtl/a_buffer_pingpong_if.sv
// Bus bundle for a_buffer_pingpong: valid/ready write port with tile-end
// marker, streaming read port and buffer status flags.
// Optional macro A_BUF_REPLAY_EN adds the rd_replay request line.
interface a_buffer_pingpong_if #(
  parameter int LANE_NUM = 16,
  parameter int DATA_W   = 264
);
  logic                       wr_valid;
  logic                       wr_ready;
  logic [LANE_NUM*DATA_W-1:0] wr_data;
  logic                       wr_last;
  logic                       rd_en;
  logic                       rd_valid;
  logic [LANE_NUM*DATA_W-1:0] rd_data;
  logic                       rd_last;
  logic [1:0]                 half_full;
  logic                       wr_overflow;
`ifdef A_BUF_REPLAY_EN
  logic                       rd_replay;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en, rd_replay,
    input  wr_ready, rd_valid, rd_data, rd_last, half_full, wr_overflow
  );
  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en, rd_replay,
    output wr_ready, rd_valid, rd_data, rd_last, half_full, wr_overflow
  );
`else
  modport master (
    output wr_valid, wr_data, wr_last, rd_en,
    input  wr_ready, rd_valid, rd_data, rd_last, half_full, wr_overflow
  );
  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en,
    output wr_ready, rd_valid, rd_data, rd_last, half_full, wr_overflow
  );
`endif
endinterface

// File: rtl/a_buffer_pingpong.sv
// Ping-pong A-operand buffer: two tile halves of DEPTH rows x LANE_NUM banks.
// The loader fills one half while the PE array streams the other.
// Optional macro A_BUF_REPLAY_EN: rd_replay on the final read of a tile keeps
// the tile resident so it can be streamed again.
module a_buffer_pingpong #(
  parameter int LANE_NUM = 16,
  parameter int DATA_W   = 264,
  parameter int DEPTH    = 8
) (
  input logic                clk,
  input logic                rst_n,
  a_buffer_pingpong_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ROW_W  = LANE_NUM * DATA_W;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } half_state_t;

  // Storage is intentionally not reset; rows are undefined until written.
  logic [ROW_W-1:0]  mem_r [2][DEPTH];

  half_state_t       state_r   [2];
  half_state_t       state_nxt_s [2];
  logic [CNT_W-1:0]  len_r     [2];
  logic [CNT_W-1:0]  len_nxt_s [2];
  logic              wr_sel_r, wr_sel_nxt_s;
  logic              rd_sel_r, rd_sel_nxt_s;
  logic [ADDR_W-1:0] wr_row_r, wr_row_nxt_s;
  logic [ADDR_W-1:0] rd_row_r, rd_row_nxt_s;

  logic              wr_ready_r, wr_ready_nxt_s;
  logic              rd_valid_r, rd_last_r, wr_overflow_r;
  logic [1:0]        half_full_r, half_full_nxt_s;
  logic [ROW_W-1:0]  rd_data_r;

  logic              wr_accept_s, wr_done_s;
  logic              readable_s, rd_fire_s, rd_final_s, replay_s;

`ifdef A_BUF_REPLAY_EN
  assign replay_s = bus.rd_replay;
`else
  assign replay_s = 1'b0;
`endif

  // Only a completed tile (FULL) or one already streaming may be read; a tile
  // completing this cycle is still FILLING here, so same-cycle reads ignore it.
  assign readable_s  = (state_r[rd_sel_r] == FULL) || (state_r[rd_sel_r] == DRAINING);
  assign wr_accept_s = bus.wr_valid && wr_ready_r;
  assign wr_done_s   = wr_accept_s && (bus.wr_last || (wr_row_r == ADDR_W'(DEPTH - 1)));
  assign rd_fire_s   = bus.rd_en && readable_s;
  assign rd_final_s  = rd_fire_s && (CNT_W'(rd_row_r) == (len_r[rd_sel_r] - CNT_W'(1)));

  // Next-state logic for both halves and the write/read pointers.
  // Writer and reader never target the same half in the same cycle, because
  // the writer needs EMPTY/FILLING and the reader needs FULL/DRAINING.
  always_comb begin
    state_nxt_s  = state_r;
    len_nxt_s    = len_r;
    wr_sel_nxt_s = wr_sel_r;
    wr_row_nxt_s = wr_row_r;
    rd_sel_nxt_s = rd_sel_r;
    rd_row_nxt_s = rd_row_r;

    if (wr_accept_s) begin
      if (wr_done_s) begin
        state_nxt_s[wr_sel_r] = FULL;
        len_nxt_s[wr_sel_r]   = CNT_W'(wr_row_r) + CNT_W'(1);
        wr_sel_nxt_s          = ~wr_sel_r;
        wr_row_nxt_s          = '0;
      end else begin
        state_nxt_s[wr_sel_r] = FILLING;
        wr_row_nxt_s          = wr_row_r + ADDR_W'(1);
      end
    end else begin
      wr_row_nxt_s = wr_row_r;
    end

    if (rd_fire_s) begin
      if (rd_final_s) begin
        rd_row_nxt_s = '0;
        if (replay_s) begin
          state_nxt_s[rd_sel_r] = FULL;
        end else begin
          state_nxt_s[rd_sel_r] = EMPTY;
          rd_sel_nxt_s          = ~rd_sel_r;
        end
      end else begin
        state_nxt_s[rd_sel_r] = DRAINING;
        rd_row_nxt_s          = rd_row_r + ADDR_W'(1);
      end
    end else begin
      rd_row_nxt_s = rd_row_r;
    end

    wr_ready_nxt_s = (state_nxt_s[wr_sel_nxt_s] == EMPTY) ||
                     (state_nxt_s[wr_sel_nxt_s] == FILLING);
    for (int h = 0; h < 2; h++) begin
      half_full_nxt_s[h] = (state_nxt_s[h] == FULL) || (state_nxt_s[h] == DRAINING);
    end
  end

  // Control state, status flags and the registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int h = 0; h < 2; h++) begin
        state_r[h] <= EMPTY;
        len_r[h]   <= '0;
      end
      wr_sel_r      <= 1'b0;
      rd_sel_r      <= 1'b0;
      wr_row_r      <= '0;
      rd_row_r      <= '0;
      wr_ready_r    <= 1'b1;
      rd_valid_r    <= 1'b0;
      rd_last_r     <= 1'b0;
      rd_data_r     <= '0;
      half_full_r   <= 2'b00;
      wr_overflow_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      len_r         <= len_nxt_s;
      wr_sel_r      <= wr_sel_nxt_s;
      rd_sel_r      <= rd_sel_nxt_s;
      wr_row_r      <= wr_row_nxt_s;
      rd_row_r      <= rd_row_nxt_s;
      wr_ready_r    <= wr_ready_nxt_s;
      rd_valid_r    <= rd_fire_s;
      rd_last_r     <= rd_final_s;
      half_full_r   <= half_full_nxt_s;
      wr_overflow_r <= wr_overflow_r | (bus.wr_valid & ~wr_ready_r);
      if (rd_fire_s) begin
        rd_data_r <= mem_r[rd_sel_r][rd_row_r];
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Row storage write port.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_sel_r][wr_row_r] <= bus.wr_data;
    end
  end

  assign bus.wr_ready    = wr_ready_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.rd_data     = rd_data_r;
  assign bus.rd_last     = rd_last_r;
  assign bus.half_full   = half_full_r;
  assign bus.wr_overflow = wr_overflow_r;
endmodule

// File: tb/tb_a_buffer_pingpong.sv
// Self-checking bench for a_buffer_pingpong. A tile-level FIFO model predicts
// every output each cycle; directed scenarios add literal spot checks.
// Build with A_BUF_REPLAY_EN defined to also exercise tile replay.
module tb_a_buffer_pingpong;
  localparam int LANE_NUM = 16;
  localparam int DATA_W   = 264;
  localparam int DEPTH    = 8;
  localparam int ROW_W    = LANE_NUM * DATA_W;

  logic clk = 1'b0;
  logic rst_n;

  a_buffer_pingpong_if #(.LANE_NUM(LANE_NUM), .DATA_W(DATA_W)) bus ();

  a_buffer_pingpong #(.LANE_NUM(LANE_NUM), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: completed tiles in arrival order (rows + lengths), the tile being
  // filled, read position inside the head tile and the half it lives in.
  logic [ROW_W-1:0] m_rows[$];
  int               m_lens[$];
  logic [ROW_W-1:0] m_pend[$];
  int               m_rdpos;
  int               m_rd_half;
  logic             e_wr_ready, e_rd_valid, e_rd_last, e_ovf;
  logic [1:0]       e_half_full;
  logic [ROW_W-1:0] e_rd_data;

  function automatic logic [ROW_W-1:0] mk_row(input int tag, input int r);
    logic [ROW_W-1:0] row;
    logic [23:0]      pat;
    row = '0;
    for (int k = 0; k < LANE_NUM; k++) begin
      pat = {8'(tag), 8'(r), 8'(k)};
      for (int b = 0; b < DATA_W; b++) row[k*DATA_W + b] = pat[b % 24];
    end
    return row;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, got, want, $time);
    end
  endtask

  task automatic check_data(input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] want);
    int k;
    total++;
    if (got !== want) begin
      bad++;
      k = 0;
      while (k < LANE_NUM - 1 && got[k*DATA_W +: DATA_W] === want[k*DATA_W +: DATA_W]) k++;
      $display("FAIL rd_data bank %0d got=%h want=%h @%0t", k,
               got[k*DATA_W +: DATA_W], want[k*DATA_W +: DATA_W], $time);
    end
  endtask

  task automatic m_reset();
    m_rows.delete();
    m_lens.delete();
    m_pend.delete();
    m_rdpos     = 0;
    m_rd_half   = 0;
    e_wr_ready  = 1'b1;
    e_rd_valid  = 1'b0;
    e_rd_last   = 1'b0;
    e_ovf       = 1'b0;
    e_half_full = 2'b00;
    e_rd_data   = '0;
  endtask

  function automatic bit replay_now();
`ifdef A_BUF_REPLAY_EN
    return bus.rd_replay;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock using the inputs that the next edge samples.
  task automatic m_step();
    logic ready_pre;
    int   n_pre, hl;
    if (!rst_n) begin
      m_reset();
      return;
    end
    ready_pre = e_wr_ready;
    n_pre     = m_lens.size();
    if (bus.rd_en && n_pre > 0) begin
      e_rd_data  = m_rows[m_rdpos];
      e_rd_valid = 1'b1;
      e_rd_last  = (m_rdpos == m_lens[0] - 1);
      if (e_rd_last) begin
        m_rdpos = 0;
        if (!replay_now()) begin
          hl = m_lens[0];
          for (int i = 0; i < hl; i++) void'(m_rows.pop_front());
          void'(m_lens.pop_front());
          m_rd_half = 1 - m_rd_half;
        end
      end else begin
        m_rdpos++;
      end
    end else begin
      e_rd_valid = 1'b0;
      e_rd_last  = 1'b0;
    end
    if (bus.wr_valid && !ready_pre) e_ovf = 1'b1;
    if (bus.wr_valid && ready_pre) begin
      m_pend.push_back(bus.wr_data);
      if (bus.wr_last || m_pend.size() == DEPTH) begin
        foreach (m_pend[i]) m_rows.push_back(m_pend[i]);
        m_lens.push_back(m_pend.size());
        m_pend.delete();
      end
    end
    e_wr_ready  = (m_lens.size() < 2);
    e_half_full = 2'b00;
    if (m_lens.size() >= 1) e_half_full[m_rd_half] = 1'b1;
    if (m_lens.size() >= 2) e_half_full[1 - m_rd_half] = 1'b1;
  endtask

  // Compare every output against the model on each falling edge, then advance it.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      check("wr_ready",    64'(bus.wr_ready),    64'(e_wr_ready));
      check("rd_valid",    64'(bus.rd_valid),    64'(e_rd_valid));
      check("rd_last",     64'(bus.rd_last),     64'(e_rd_last));
      check("half_full",   64'(bus.half_full),   64'(e_half_full));
      check("wr_overflow", 64'(bus.wr_overflow), 64'(e_ovf));
      check_data(bus.rd_data, e_rd_data);
      m_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tile(input int tag, input int n, input bit use_last, output int stalls);
    stalls = 0;
    for (int r = 0; r < n; r++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = mk_row(tag, r);
      bus.wr_last  = use_last && (r == n - 1);
      while (!bus.wr_ready && stalls < 50) begin
        step();
        stalls++;
      end
      if (!bus.wr_ready) begin
        total++;
        bad++;
        $display("FAIL wr_timeout tag=%0d got=wr_ready low want=high", tag);
        break;
      end
      step();
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic read_n(input int n, input int l1, input int l2);
    bus.rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check("lit_rd_valid", 64'(bus.rd_valid), 64'(1'b1));
      check("lit_rd_last",  64'(bus.rd_last),  64'((i == l1) || (i == l2)));
    end
    bus.rd_en = 1'b0;
  endtask

  int st, stall_sum, nvalid;

  initial begin
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.rd_en    = 1'b0;
`ifdef A_BUF_REPLAY_EN
    bus.rd_replay = 1'b0;
`endif
    step();
    step();
    check("rst_wr_ready",  64'(bus.wr_ready),  64'(1'b1));
    check("rst_half_full", 64'(bus.half_full), 64'(2'b00));
    check("rst_rd_valid",  64'(bus.rd_valid),  64'(1'b0));
    rst_n = 1'b1;
    step();

    // Full 8-row tile without wr_last, then a back-to-back drain.
    write_tile(1, 8, 1'b0, st);
    check("t1_half_full", 64'(bus.half_full), 64'(2'b01));
    check("t1_wr_ready",  64'(bus.wr_ready),  64'(1'b1));
    read_n(8, 7, -1);
    check("t1_drained", 64'(bus.half_full), 64'(2'b00));

    // 3-row tile then 5-row tile: both halves occupied.
    write_tile(2, 3, 1'b1, st);
    write_tile(3, 5, 1'b1, st);
    check("t2_half_full", 64'(bus.half_full), 64'(2'b11));
    check("t2_wr_ready",  64'(bus.wr_ready),  64'(1'b0));

    // Offer a row while blocked, keep offering through the drain.
    bus.wr_valid = 1'b1;
    bus.wr_data  = mk_row(4, 0);
    step();
    step();
    step();
    check("t3_overflow", 64'(bus.wr_overflow), 64'(1'b1));
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.wr_data = mk_row(4, i + 1);
      check("t3_rd_last", 64'(bus.rd_last), 64'((i == 2) || (i == 7)));
      if (i == 1) check("t3_ready_lo", 64'(bus.wr_ready), 64'(1'b0));
      if (i == 2) check("t3_ready_hi", 64'(bus.wr_ready), 64'(1'b1));
    end
    bus.rd_en    = 1'b0;
    bus.wr_valid = 1'b0;
    write_tile(5, 3, 1'b1, st);
    read_n(8, 7, -1);
    check("t3_sticky", 64'(bus.wr_overflow), 64'(1'b1));

    // Concurrent fill/drain of four 4-row tiles.
    stall_sum = 0;
    nvalid    = 0;
    fork
      begin
        for (int t = 0; t < 4; t++) begin
          write_tile(10 + t, 4, 1'b1, st);
          stall_sum += st;
        end
      end
      begin
        bus.rd_en = 1'b1;
        for (int c = 0; c < 60 && nvalid < 16; c++) begin
          step();
          if (bus.rd_valid) nvalid++;
        end
        bus.rd_en = 1'b0;
      end
    join
    check("t4_rows",   64'(nvalid),        64'(16));
    check("t4_stalls", 64'(stall_sum),     64'(0));
    check("t4_empty",  64'(bus.half_full), 64'(2'b00));

    // Read with nothing buffered, then reset in the middle of a fill.
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("t5_rd_empty", 64'(bus.rd_valid), 64'(1'b0));
    write_tile(6, 4, 1'b0, st);
    bus.wr_valid = 1'b1;
    bus.wr_data  = mk_row(6, 4);
    rst_n        = 1'b0;
    step();
    check("t5_rst_wr_ready",  64'(bus.wr_ready),     64'(1'b1));
    check("t5_rst_half_full", 64'(bus.half_full),    64'(2'b00));
    check("t5_rst_overflow",  64'(bus.wr_overflow),  64'(1'b0));
    check("t5_rst_rd_data",   bus.rd_data[63:0],     64'(0));
    rst_n        = 1'b1;
    bus.wr_valid = 1'b0;
    step();
    write_tile(20, 2, 1'b1, st);
    read_n(2, 1, -1);
    check("t5_empty", 64'(bus.half_full), 64'(2'b00));

`ifdef A_BUF_REPLAY_EN
    // Replay a 4-row tile once, then release it.
    write_tile(30, 4, 1'b1, st);
    bus.rd_replay = 1'b1;
    read_n(4, 3, -1);
    bus.rd_replay = 1'b0;
    check("t6_kept", 64'(bus.half_full), 64'(2'b10));
    read_n(4, 3, -1);
    check("t6_freed", 64'(bus.half_full), 64'(2'b00));
`endif

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
